// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the sequential ALU.
package alu_seq_pkg;

    // Operation codes carried on the op input.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011
    } op_e;

    // Top-level control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Which algorithm the iterative datapath runs.
    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    // Codes above OP_DIV are reserved and reported through err.
    function automatic logic is_legal_op(input logic [2:0] code);
        return code <= 3'(OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// W-step iterative datapath shared by multiply and divide.
// Both algorithms work on one {hi, lo} register pair:
//   mul: hi accumulates partial products, lo holds the multiplier and
//        collects the low product bits as the pair shifts right.
//   div: hi is the partial remainder, lo holds the dividend and collects
//        quotient bits as the pair shifts left (restoring division).
// Operands are captured on start; one step runs per clock after that and
// done pulses for one cycle once the last step has been written.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  iter_mode_e       mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   res
);

    localparam int CW = $clog2(W);

    logic             busy;
    iter_mode_e       mode_q;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic [W-1:0]     opnd_b;

    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic             div_ge;
    logic [W-1:0]     div_diff;
    logic [W-1:0]     hi_next;
    logic [W-1:0]     lo_next;

    // One step of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_b} : '0);
        div_shift = {hi, lo[W-1]};
        div_ge    = div_shift >= {1'b0, opnd_b};
        // When div_ge holds the true difference is below opnd_b, so the
        // low W bits of the subtraction are exact.
        div_diff  = div_shift[W-1:0] - opnd_b;
        if (mode_q == MODE_MUL) begin
            hi_next = mul_sum[W:1];
            lo_next = {mul_sum[0], lo[W-1:1]};
        end else begin
            hi_next = div_ge ? div_diff : div_shift[W-1:0];
            lo_next = {lo[W-2:0], div_ge};
        end
    end

    // Operand capture, step counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= MODE_MUL;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd_b <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                mode_q <= mode;
                cnt    <= CW'(W - 1);
                hi     <= '0;
                lo     <= a;
                opnd_b <= b;
            end else if (busy) begin
                hi <= hi_next;
                lo <= lo_next;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign res = {hi, lo};

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit ALU: add/sub in one cycle, mul/div over W cycles.
// Valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; the producer holds its data stable until that edge and
// ready never depends combinationally on valid.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result,
    output logic             err,
    output state_e           state
);

    logic             accept;
    logic             iter_start;
    iter_mode_e       iter_mode;
    logic             iter_done;
    logic [2*W-1:0]   iter_res;
    logic [W:0]       add_sum;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign add_sum  = {1'b0, a} + {1'b0, b};

    // Only mul and a divide with a non-zero divisor need the iterator.
    assign iter_start = accept && ((op == 3'(OP_MUL)) ||
                                   ((op == 3'(OP_DIV)) && (b != '0)));
    assign iter_mode  = (op == 3'(OP_DIV)) ? MODE_DIV : MODE_MUL;

    alu_seq_iter #(.W(W)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (iter_start),
        .mode  (iter_mode),
        .a     (a),
        .b     (b),
        .done  (iter_done),
        .res   (iter_res)
    );

    // Control FSM with registered result, err and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_legal_op(op)) begin
                            result    <= '0;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            case (op_e'(op))
                                OP_ADD: begin
                                    result    <= {{(W-1){1'b0}}, add_sum};
                                    err       <= 1'b0;
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end
                                OP_SUB: begin
                                    result    <= {{W{1'b0}}, a} - {{W{1'b0}}, b};
                                    err       <= 1'b0;
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end
                                OP_MUL: begin
                                    state <= BUSY;
                                end
                                OP_DIV: begin
                                    if (b == '0) begin
                                        result    <= '1;
                                        err       <= 1'b1;
                                        out_valid <= 1'b1;
                                        state     <= DONE;
                                    end else begin
                                        state <= BUSY;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                BUSY: begin
                    if (iter_done) begin
                        result    <= iter_res;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at W=8.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [2:0]      op = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  result;
    logic            err;
    state_e          state;

    int total = 0;
    int bad   = 0;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, measure latency, optionally backpressure, then drain.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                          input bit early, input int hold,
                          output logic [15:0] res, output logic e, output int lat,
                          output bit busy_ok, output bit stable_ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
        busy_ok = !in_ready;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
        end
        res = result;
        e = err;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (result !== res || err !== e || !out_valid || in_ready) stable_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] r;
        logic        e;
        int          lat;
        bit          busy_ok;
        bit          stable_ok;
        bit          flag;
        int          guard;

        vecs[0]  = '{8'd200, 8'd100, 3'b000, 16'h012C, 1'b0, 1};
        vecs[1]  = '{8'd5,   8'd7,   3'b001, 16'hFFFE, 1'b0, 1};
        vecs[2]  = '{8'd255, 8'd255, 3'b000, 16'h01FE, 1'b0, 1};
        vecs[3]  = '{8'd200, 8'd100, 3'b010, 16'h4E20, 1'b0, 9};
        vecs[4]  = '{8'd255, 8'd255, 3'b010, 16'hFE01, 1'b0, 9};
        vecs[5]  = '{8'd0,   8'd77,  3'b010, 16'h0000, 1'b0, 9};
        vecs[6]  = '{8'd200, 8'd7,   3'b011, 16'h041C, 1'b0, 9};
        vecs[7]  = '{8'd9,   8'd0,   3'b011, 16'hFFFF, 1'b1, 1};
        vecs[8]  = '{8'd255, 8'd1,   3'b011, 16'h00FF, 1'b0, 9};
        vecs[9]  = '{8'd7,   8'd200, 3'b011, 16'h0700, 1'b0, 9};
        vecs[10] = '{8'd12,  8'd34,  3'b110, 16'h0000, 1'b1, 1};
        vecs[11] = '{8'd1,   8'd1,   3'b100, 16'h0000, 1'b1, 1};
        vecs[12] = '{8'd0,   8'd1,   3'b001, 16'hFFFF, 1'b0, 1};
        vecs[13] = '{8'd100, 8'd30,  3'b001, 16'h0046, 1'b0, 1};
        vecs[14] = '{8'd255, 8'd255, 3'b011, 16'h0001, 1'b0, 9};
        vecs[15] = '{8'd16,  8'd15,  3'b010, 16'h00F0, 1'b0, 9};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_state", {30'd0, state}, {30'd0, IDLE});
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 2, r, e, lat, busy_ok, stable_ok);
            check($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_in_ready_low", i), {31'd0, busy_ok}, 32'd1);
            check($sformatf("vec%0d_held_stable", i), {31'd0, stable_ok}, 32'd1);
        end

        // Early out_ready during a multiply must not shorten it
        run_op(8'd13, 8'd11, 3'b010, 1'b1, 0, r, e, lat, busy_ok, stable_ok);
        check("early_ready_result", {16'd0, r}, 32'h0000_008F);
        check("early_ready_latency", lat, 9);

        // Reset in the middle of a multiply
        @(negedge clk);
        a = 8'd200; b = 8'd100; op = 3'b010; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_state", {30'd0, state}, {30'd0, IDLE});
        out_ready = 1'b1;
        flag = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) flag = 1'b1;
        end
        out_ready = 1'b0;
        check("abort_no_stale_result", {31'd0, flag}, 32'd0);

        // Backpressure: held result, ignored request, accept right after drain
        @(negedge clk);
        a = 8'd3; b = 8'd4; op = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd50; b = 8'd60; op = 3'b000;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_first_result", {16'd0, result}, 32'd7);
        flag = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (result !== 16'd7 || !out_valid || in_ready || err !== 1'b0) flag = 1'b0;
        end
        check("bp_held_and_ignored", {31'd0, flag}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted_next_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_result", {16'd0, result}, 32'd110);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Random operations against a reference model
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  ra, rb;
            logic [2:0]  rop;
            logic [15:0] er;
            logic        ee;
            int          el;
            ra  = 8'($urandom);
            rb  = (i % 8 == 0) ? 8'd0 : 8'($urandom);
            rop = 3'($urandom_range(0, 4));
            if (i % 10 == 9) rop = 3'($urandom_range(4, 7));
            ee = 1'b0;
            el = 1;
            case (rop)
                3'd0: er = 16'(ra) + 16'(rb);
                3'd1: er = 16'(ra) - 16'(rb);
                3'd2: begin er = 16'(ra) * 16'(rb); el = 9; end
                3'd3: begin
                    if (rb == 0) begin er = 16'hFFFF; ee = 1'b1; end
                    else begin er = {ra % rb, ra / rb}; el = 9; end
                end
                default: begin er = 16'h0000; ee = 1'b1; end
            endcase
            run_op(ra, rb, rop, 1'b0, $urandom_range(0, 3), r, e, lat, busy_ok, stable_ok);
            check($sformatf("rand%0d_result", i), {16'd0, r}, {16'd0, er});
            check($sformatf("rand%0d_err", i), {31'd0, e}, {31'd0, ee});
            check($sformatf("rand%0d_latency", i), lat, el);
            check($sformatf("rand%0d_stable", i), {31'd0, stable_ok}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
